// File: rtl/game_director.sv
// game_director: top-level sequencer for game_logic. Runs the game flow FSM,
// holds game_logic in reset between games, gates its frame strobe, stretches
// button presses to exactly one frame and schedules difficulty from the score.
module game_director #(
  parameter int unsigned COUNT_FRAMES = 180,
  parameter int unsigned DEATH_FRAMES = 90,
  parameter int unsigned LEVEL_SHIFT  = 10,
  parameter int unsigned BASE_GRAVITY = 1,
  parameter int unsigned BASE_JUMP    = 190,
  parameter int unsigned JUMP_STEP    = 40,
  parameter int unsigned BASE_DUCK    = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_new_frame,
  input  logic        i_start_btn,
  input  logic        i_pause_btn,
  input  logic        i_jump_btn,
  input  logic        i_duck_btn,
  input  logic        i_left_btn,
  input  logic        i_right_btn,
  input  logic        i_game_over_in,
  input  logic [15:0] i_player_score,
  output logic        o_game_rst,
  output logic        o_game_new_frame,
  output logic        o_jump,
  output logic        o_duck,
  output logic        o_left,
  output logic        o_right,
  output logic [3:0]  o_speed,
  output logic [5:0]  o_gravity,
  output logic [7:0]  o_duck_limit,
  output logic [9:0]  o_vertical_jump,
  output logic [2:0]  o_state,
  output logic [2:0]  o_level,
  output logic [15:0] o_high_score
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RUN       = 3'd2,
    S_PAUSE     = 3'd3,
    S_DYING     = 3'd4,
    S_OVER      = 3'd5
  } state_t;

  function automatic logic [2:0] level_of(input logic [15:0] score);
    logic [15:0] s;
    s = score >> LEVEL_SHIFT;
    return (s > 16'd7) ? 3'd7 : s[2:0];
  endfunction

  function automatic logic [1:0] sh_of(input logic [2:0] lvl);
    if (lvl <= 3'd1)      return 2'd0;
    else if (lvl <= 3'd4) return 2'd1;
    else                  return 2'd2;
  endfunction

  function automatic logic [5:0] grav_of(input logic [1:0] sh);
    logic [31:0] f;
    f = BASE_GRAVITY << sh;
    return (f > 32'd63) ? 6'd63 : f[5:0];
  endfunction

  function automatic logic [9:0] jump_of(input logic [1:0] sh);
    logic [31:0] f;
    f = BASE_JUMP + 32'(sh) * JUMP_STEP;
    return (f > 32'd1023) ? 10'd1023 : f[9:0];
  endfunction

  function automatic logic [7:0] duck_of(input logic [1:0] sh);
    logic [31:0] f;
    f = BASE_DUCK >> sh;
    if (f == 32'd0)        return 8'd1;
    else if (f > 32'd255)  return 8'd255;
    else                   return f[7:0];
  endfunction

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_start_q, r_pause_q;
  logic [3:0]  r_ctl_q, r_latch, r_ctrl;
  logic        r_game_rst, r_game_new_frame;
  logic [2:0]  r_level;
  logic [3:0]  r_speed;
  logic [5:0]  r_gravity;
  logic [7:0]  r_duck_limit;
  logic [9:0]  r_vertical_jump;
  logic [15:0] r_high_score;

  logic [3:0]  w_ctl;
  logic [3:0]  w_ctl_p;
  logic        w_start_p, w_pause_p;
  logic [2:0]  w_level;
  logic [1:0]  w_sh;

  // Control bit order: [0]=jump [1]=duck [2]=left [3]=right
  assign w_ctl     = {i_right_btn, i_left_btn, i_duck_btn, i_jump_btn};
  assign w_ctl_p   = w_ctl & ~r_ctl_q;
  assign w_start_p = i_start_btn & ~r_start_q;
  assign w_pause_p = i_pause_btn & ~r_pause_q;
  assign w_level   = level_of(i_player_score);
  assign w_sh      = sh_of(w_level);

  // Game flow FSM with frame gating, control latching and difficulty scheduling
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_start_q        <= 1'b0;
      r_pause_q        <= 1'b0;
      r_ctl_q          <= '0;
      r_latch          <= '0;
      r_ctrl           <= '0;
      r_game_rst       <= 1'b1;
      r_game_new_frame <= 1'b0;
      r_level          <= '0;
      r_speed          <= 4'd1;
      r_gravity        <= grav_of(2'd0);
      r_duck_limit     <= duck_of(2'd0);
      r_vertical_jump  <= jump_of(2'd0);
      r_high_score     <= '0;
    end else begin
      r_start_q        <= i_start_btn;
      r_pause_q        <= i_pause_btn;
      r_ctl_q          <= w_ctl;
      r_game_new_frame <= 1'b0;

      // Difficulty only moves on a forwarded frame; COUNTDOWN entry below overrides
      if (r_game_new_frame) begin
        r_level         <= w_level;
        r_speed         <= 4'd1 << w_sh;
        r_gravity       <= grav_of(w_sh);
        r_duck_limit    <= duck_of(w_sh);
        r_vertical_jump <= jump_of(w_sh);
      end

      case (r_state)
        S_IDLE, S_OVER: begin
          if (w_start_p) begin
            r_state         <= S_COUNTDOWN;
            r_cnt           <= 16'(COUNT_FRAMES);
            r_game_rst      <= 1'b1;
            r_level         <= '0;
            r_speed         <= 4'd1;
            r_gravity       <= grav_of(2'd0);
            r_duck_limit    <= duck_of(2'd0);
            r_vertical_jump <= jump_of(2'd0);
          end
        end
        S_COUNTDOWN: begin
          if (i_new_frame) begin
            if (r_cnt == 16'd1) begin
              r_state    <= S_RUN;
              r_game_rst <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
        end
        S_RUN: begin
          if (i_game_over_in) begin
            r_state <= S_DYING;
            r_cnt   <= 16'(DEATH_FRAMES);
            if (i_player_score > r_high_score) r_high_score <= i_player_score;
          end else if (w_pause_p) begin
            r_state <= S_PAUSE;
          end else begin
            r_game_new_frame <= i_new_frame;
          end
        end
        S_PAUSE: begin
          if (w_pause_p) r_state <= S_RUN;
        end
        S_DYING: begin
          if (i_new_frame) begin
            if (r_cnt == 16'd1) begin
              r_state    <= S_OVER;
              r_game_rst <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_game_rst <= 1'b1;
        end
      endcase

      // Presses accumulate between frames and are published on the forwarded frame,
      // including a press landing in that very cycle; PAUSE freezes both
      if (r_state == S_RUN) begin
        if (r_game_new_frame) begin
          r_ctrl  <= r_latch | w_ctl_p;
          r_latch <= '0;
        end else begin
          r_latch <= r_latch | w_ctl_p;
        end
      end else if (r_state != S_PAUSE) begin
        r_latch <= '0;
        r_ctrl  <= '0;
      end
    end
  end

  assign o_game_rst       = r_game_rst;
  assign o_game_new_frame = r_game_new_frame;
  assign o_jump           = r_ctrl[0];
  assign o_duck           = r_ctrl[1];
  assign o_left           = r_ctrl[2];
  assign o_right          = r_ctrl[3];
  assign o_speed          = r_speed;
  assign o_gravity        = r_gravity;
  assign o_duck_limit     = r_duck_limit;
  assign o_vertical_jump  = r_vertical_jump;
  assign o_state          = r_state;
  assign o_level          = r_level;
  assign o_high_score     = r_high_score;

endmodule

// File: tb/tb_game_director.sv
// Directed testbench for game_director with short countdown/death timers.
module tb_game_director;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_frame = 1'b0;
  logic        start_btn = 1'b0, pause_btn = 1'b0;
  logic        jump_btn = 1'b0, duck_btn = 1'b0, left_btn = 1'b0, right_btn = 1'b0;
  logic        game_over_in = 1'b0;
  logic [15:0] player_score = '0;
  logic        game_rst, game_new_frame, jump, duck, left, right;
  logic [3:0]  speed;
  logic [5:0]  gravity;
  logic [7:0]  duck_limit;
  logic [9:0]  vertical_jump;
  logic [2:0]  state, level;
  logic [15:0] high_score;

  int errors = 0;
  int checks = 0;

  game_director #(
    .COUNT_FRAMES(3),
    .DEATH_FRAMES(4),
    .LEVEL_SHIFT(10),
    .BASE_GRAVITY(1),
    .BASE_JUMP(190),
    .JUMP_STEP(40),
    .BASE_DUCK(15)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_new_frame(new_frame),
    .i_start_btn(start_btn), .i_pause_btn(pause_btn),
    .i_jump_btn(jump_btn), .i_duck_btn(duck_btn), .i_left_btn(left_btn), .i_right_btn(right_btn),
    .i_game_over_in(game_over_in), .i_player_score(player_score),
    .o_game_rst(game_rst), .o_game_new_frame(game_new_frame),
    .o_jump(jump), .o_duck(duck), .o_left(left), .o_right(right),
    .o_speed(speed), .o_gravity(gravity), .o_duck_limit(duck_limit),
    .o_vertical_jump(vertical_jump), .o_state(state), .o_level(level),
    .o_high_score(high_score)
  );

  always #5 clk = ~clk;

  // Advance n clock edges; outputs are observed 1 time unit after the edge
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    new_frame = 1'b1; cyc(1); new_frame = 1'b0;
  endtask

  task automatic press_start();
    start_btn = 1'b1; cyc(1); start_btn = 1'b0; cyc(1);
  endtask

  task automatic to_run();
    press_start();
    for (int i = 0; i < 3; i++) begin frame(); cyc(1); end
  endtask

  task automatic die(input logic [15:0] score);
    player_score = score; game_over_in = 1'b1; cyc(1); game_over_in = 1'b0;
    for (int i = 0; i < 4; i++) begin frame(); cyc(1); end
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(2); rst = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (game_rst !== 1'b1) begin errors++; $display("FAIL rst_game_rst got=%0d exp=1", game_rst); end
    checks++; if (speed !== 4'd1) begin errors++; $display("FAIL rst_speed got=%0d exp=1", speed); end
    checks++; if (gravity !== 6'd1) begin errors++; $display("FAIL rst_gravity got=%0d exp=1", gravity); end
    checks++; if (vertical_jump !== 10'd190) begin errors++; $display("FAIL rst_vjump got=%0d exp=190", vertical_jump); end
    checks++; if (duck_limit !== 8'd15) begin errors++; $display("FAIL rst_duck got=%0d exp=15", duck_limit); end
    checks++; if (high_score !== 16'd0) begin errors++; $display("FAIL rst_high got=%0d exp=0", high_score); end
    checks++; if (game_new_frame !== 1'b0) begin errors++; $display("FAIL rst_gnf got=%0d exp=0", game_new_frame); end
  endtask

  task automatic test_countdown();
    start_btn = 1'b1; cyc(1); start_btn = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL cd_state got=%0d exp=1", state); end
    frame(); cyc(1); frame(); cyc(1);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL cd_hold got=%0d exp=1", state); end
    checks++; if (game_rst !== 1'b1) begin errors++; $display("FAIL cd_game_rst got=%0d exp=1", game_rst); end
    frame();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL cd_run got=%0d exp=2", state); end
    checks++; if (game_rst !== 1'b0) begin errors++; $display("FAIL run_game_rst got=%0d exp=0", game_rst); end
    checks++; if (game_new_frame !== 1'b0) begin errors++; $display("FAIL cd_last_gnf got=%0d exp=0", game_new_frame); end
    cyc(2); frame();
    checks++; if (game_new_frame !== 1'b1) begin errors++; $display("FAIL run_gnf got=%0d exp=1", game_new_frame); end
    cyc(1);
    checks++; if (game_new_frame !== 1'b0) begin errors++; $display("FAIL run_gnf_pulse got=%0d exp=0", game_new_frame); end
  endtask

  task automatic test_controls();
    cyc(2); jump_btn = 1'b1; cyc(1); jump_btn = 1'b0; cyc(2);
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL jump_early got=%0d exp=0", jump); end
    frame();
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL jump_gnf_cycle got=%0d exp=0", jump); end
    cyc(1);
    checks++; if (jump !== 1'b1) begin errors++; $display("FAIL jump_set got=%0d exp=1", jump); end
    cyc(3);
    checks++; if (jump !== 1'b1) begin errors++; $display("FAIL jump_held got=%0d exp=1", jump); end
    frame(); cyc(1);
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL jump_clear got=%0d exp=0", jump); end
    // press landing exactly in the forwarded-frame cycle
    cyc(2); frame(); duck_btn = 1'b1; cyc(1); duck_btn = 1'b0;
    checks++; if (duck !== 1'b1) begin errors++; $display("FAIL duck_same_cycle got=%0d exp=1", duck); end
    checks++; if (left !== 1'b0) begin errors++; $display("FAIL left_idle got=%0d exp=0", left); end
    frame(); cyc(1);
    checks++; if (duck !== 1'b0) begin errors++; $display("FAIL duck_clear got=%0d exp=0", duck); end
  endtask

  task automatic test_level();
    player_score = 16'd2048; cyc(1); frame();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL lvl_midframe got=%0d exp=0", level); end
    cyc(1);
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL lvl2 got=%0d exp=2", level); end
    checks++; if (speed !== 4'd2) begin errors++; $display("FAIL lvl2_speed got=%0d exp=2", speed); end
    checks++; if (gravity !== 6'd2) begin errors++; $display("FAIL lvl2_grav got=%0d exp=2", gravity); end
    checks++; if (vertical_jump !== 10'd230) begin errors++; $display("FAIL lvl2_vjump got=%0d exp=230", vertical_jump); end
    checks++; if (duck_limit !== 8'd7) begin errors++; $display("FAIL lvl2_duck got=%0d exp=7", duck_limit); end
    player_score = 16'hFFFF; frame(); cyc(1);
    checks++; if (level !== 3'd7) begin errors++; $display("FAIL lvl7 got=%0d exp=7", level); end
    checks++; if (speed !== 4'd4) begin errors++; $display("FAIL lvl7_speed got=%0d exp=4", speed); end
    checks++; if (gravity !== 6'd4) begin errors++; $display("FAIL lvl7_grav got=%0d exp=4", gravity); end
    checks++; if (vertical_jump !== 10'd270) begin errors++; $display("FAIL lvl7_vjump got=%0d exp=270", vertical_jump); end
    checks++; if (duck_limit !== 8'd3) begin errors++; $display("FAIL lvl7_duck got=%0d exp=3", duck_limit); end
  endtask

  task automatic test_pause();
    pause_btn = 1'b1; new_frame = 1'b1; cyc(1); pause_btn = 1'b0; new_frame = 1'b0;
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL pause_state got=%0d exp=3", state); end
    checks++; if (game_new_frame !== 1'b0) begin errors++; $display("FAIL pause_edge_gnf got=%0d exp=0", game_new_frame); end
    cyc(1); frame();
    checks++; if (game_new_frame !== 1'b0) begin errors++; $display("FAIL pause_gnf got=%0d exp=0", game_new_frame); end
    start_btn = 1'b1; cyc(1); start_btn = 1'b0;
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL pause_start got=%0d exp=3", state); end
    checks++; if (game_rst !== 1'b0) begin errors++; $display("FAIL pause_game_rst got=%0d exp=0", game_rst); end
    pause_btn = 1'b1; cyc(1); pause_btn = 1'b0;
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL resume_state got=%0d exp=2", state); end
    frame();
    checks++; if (game_new_frame !== 1'b1) begin errors++; $display("FAIL resume_gnf got=%0d exp=1", game_new_frame); end
    cyc(1);
  endtask

  task automatic test_game_over();
    player_score = 16'd300; game_over_in = 1'b1; cyc(1); game_over_in = 1'b0;
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL dying_state got=%0d exp=4", state); end
    checks++; if (high_score !== 16'd300) begin errors++; $display("FAIL high_300 got=%0d exp=300", high_score); end
    checks++; if (game_rst !== 1'b0) begin errors++; $display("FAIL dying_game_rst got=%0d exp=0", game_rst); end
    for (int i = 0; i < 3; i++) begin frame(); cyc(1); end
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL dying_hold got=%0d exp=4", state); end
    frame();
    checks++; if (game_new_frame !== 1'b0) begin errors++; $display("FAIL dying_gnf got=%0d exp=0", game_new_frame); end
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL over_state got=%0d exp=5", state); end
    checks++; if (game_rst !== 1'b1) begin errors++; $display("FAIL over_game_rst got=%0d exp=1", game_rst); end
    cyc(1); start_btn = 1'b1; cyc(1); start_btn = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL restart_state got=%0d exp=1", state); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL restart_level got=%0d exp=0", level); end
    checks++; if (vertical_jump !== 10'd190) begin errors++; $display("FAIL restart_vjump got=%0d exp=190", vertical_jump); end
    checks++; if (duck_limit !== 8'd15) begin errors++; $display("FAIL restart_duck got=%0d exp=15", duck_limit); end
    for (int i = 0; i < 3; i++) begin frame(); cyc(1); end
    // game over coinciding with a frame strobe
    player_score = 16'd500; game_over_in = 1'b1; new_frame = 1'b1; cyc(1);
    game_over_in = 1'b0; new_frame = 1'b0;
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL dying2_state got=%0d exp=4", state); end
    checks++; if (high_score !== 16'd500) begin errors++; $display("FAIL high_500 got=%0d exp=500", high_score); end
    checks++; if (game_new_frame !== 1'b0) begin errors++; $display("FAIL over_edge_gnf got=%0d exp=0", game_new_frame); end
    checks++; if (jump !== 1'b0 || duck !== 1'b0) begin errors++; $display("FAIL dying_ctrl got=%0d%0d exp=00", jump, duck); end
    for (int i = 0; i < 4; i++) begin frame(); cyc(1); end
    to_run(); die(16'h8000);
    checks++; if (high_score !== 16'h8000) begin errors++; $display("FAIL high_unsigned got=%0h exp=8000", high_score); end
    to_run(); die(16'd1000);
    checks++; if (high_score !== 16'h8000) begin errors++; $display("FAIL high_keep got=%0h exp=8000", high_score); end
  endtask

  task automatic test_reset_mid();
    to_run();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL mid_run got=%0d exp=2", state); end
    rst = 1'b1; cyc(1); rst = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL mid_rst_state got=%0d exp=0", state); end
    checks++; if (high_score !== 16'd0) begin errors++; $display("FAIL mid_rst_high got=%0d exp=0", high_score); end
    checks++; if (game_rst !== 1'b1) begin errors++; $display("FAIL mid_rst_game_rst got=%0d exp=1", game_rst); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_controls();
    test_level();
    test_pause();
    test_game_over();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
